// File: rtl/pe_cube_pkg.sv
// Shared definitions for the PE cube sequencer: FSM encoding, accumulator
// width default and the shift-and-saturate helper used by every PE.
package pe_cube_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int ACC_W_DEFAULT = 24;
  localparam int SAT_W         = 64;

  // Arithmetic (floor) right shift, then clamp into the signed byte range.
  function automatic logic signed [7:0] sat8(input logic signed [SAT_W-1:0] acc,
                                             input logic [4:0] shift);
    logic signed [SAT_W-1:0] sh;
    sh = acc >>> shift;
    if (sh > 64'sd127) begin
      sat8 = 8'sh7f;
    end else if (sh < -64'sd128) begin
      sat8 = 8'sh80;
    end else begin
      sat8 = sh[7:0];
    end
  endfunction

endpackage

// File: rtl/pe_cube_seq_if.sv
// Job/beat/result handshake bundle of the PE cube sequencer.
interface pe_cube_seq_if #(
  parameter int CUBE_NUM  = 3,
  parameter int BLOCK_NUM = 3,
  parameter int ARRAY_NUM = 3,
  parameter int LEN_W     = 8
);
  logic                                      iStart;
  logic [LEN_W-1:0]                          iLen;
  logic [ARRAY_NUM*BLOCK_NUM-1:0]            iSelPattern;
  logic [4:0]                                iShift;
  logic                                      iValid;
  logic                                      oReady;
  logic [8*CUBE_NUM-1:0]                     iWeight;
  logic [8*ARRAY_NUM-1:0]                    iData1;
  logic [8*ARRAY_NUM-1:0]                    iData2;
  logic [8*ARRAY_NUM*BLOCK_NUM*CUBE_NUM-1:0] oResult;
  logic                                      oResultValid;
  logic                                      iResultReady;
  logic                                      oBusy;

  modport slave (
    input  iStart, iLen, iSelPattern, iShift, iValid, iWeight, iData1, iData2, iResultReady,
    output oReady, oResult, oResultValid, oBusy
  );

  modport master (
    output iStart, iLen, iSelPattern, iShift, iValid, iWeight, iData1, iData2, iResultReady,
    input  oReady, oResult, oResultValid, oBusy
  );
endinterface

// File: rtl/pe_mac.sv
// One processing element: signed 8x8 multiply-accumulate with wrap-around
// accumulator, synchronous clear and a shifted/saturated byte view.
module pe_mac
  import pe_cube_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  input  logic [4:0]        shift,
  output logic signed [7:0] sat
);

  logic signed [ACC_W-1:0] acc_r;
  logic signed [15:0]      prod_s;

  assign prod_s = a * b;

  // Accumulator: cleared at job start, wraps modulo 2^ACC_W on each beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + ACC_W'(prod_s);
    end
  end

  assign sat = sat8(SAT_W'(acc_r), shift);

endmodule

// File: rtl/pe_cube_seq.sv
// PE cube sequencer: accumulates a job of weighted data beats across a
// CUBE x BLOCK x ARRAY grid of MACs and presents saturated byte results.
module pe_cube_seq
  import pe_cube_pkg::*;
#(
  parameter int CUBE_NUM  = 3,
  parameter int BLOCK_NUM = 3,
  parameter int ARRAY_NUM = 3,
  parameter int ACC_W     = ACC_W_DEFAULT,
  parameter int LEN_W     = 8
) (
  input logic           iClk,
  input logic           iRstN,
  pe_cube_seq_if.slave  bus
);

  localparam int PE_PER_CUBE = ARRAY_NUM * BLOCK_NUM;
  localparam int NPE         = CUBE_NUM * PE_PER_CUBE;

  state_t                 state_r;
  logic [LEN_W-1:0]       len_r;
  logic [LEN_W-1:0]       cnt_r;
  logic [PE_PER_CUBE-1:0] sel_r;
  logic [4:0]             shift_r;
  logic [8*NPE-1:0]       result_r;
  logic [8*NPE-1:0]       sat_s;
  logic                   result_valid_r;
  logic                   ready_r;
  logic                   busy_r;
  logic                   clr_s;
  logic                   en_s;
  logic                   last_s;

  assign clr_s  = (state_r == ST_IDLE) && bus.iStart && (bus.iLen != '0);
  assign en_s   = (state_r == ST_ACC) && bus.iValid;
  assign last_s = (cnt_r == (len_r - LEN_W'(1)));

  for (genvar c = 0; c < CUBE_NUM; c++) begin : g_cube
    for (genvar j = 0; j < BLOCK_NUM; j++) begin : g_blk
      for (genvar i = 0; i < ARRAY_NUM; i++) begin : g_lane
        localparam int IDX = c * PE_PER_CUBE + j * ARRAY_NUM + i;
        logic signed [7:0] a_s;

        assign a_s = sel_r[j*ARRAY_NUM+i] ? bus.iData2[i*8 +: 8] : bus.iData1[i*8 +: 8];

        pe_mac #(.ACC_W(ACC_W)) u_mac (
          .clk   (iClk),
          .rst_n (iRstN),
          .clr   (clr_s),
          .en    (en_s),
          .a     (a_s),
          .b     (bus.iWeight[c*8 +: 8]),
          .shift (shift_r),
          .sat   (sat_s[IDX*8 +: 8])
        );
      end
    end
  end

  // Job sequencer: ready/busy are registered alongside the state they mirror.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_r        <= ST_IDLE;
      len_r          <= '0;
      cnt_r          <= '0;
      sel_r          <= '0;
      shift_r        <= 5'd0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
      ready_r        <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clr_s) begin
            len_r   <= bus.iLen;
            sel_r   <= bus.iSelPattern;
            shift_r <= bus.iShift;
            cnt_r   <= '0;
            state_r <= ST_ACC;
            ready_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        ST_ACC: begin
          if (en_s) begin
            cnt_r <= cnt_r + LEN_W'(1);
            if (last_s) begin
              state_r <= ST_FLUSH;
              ready_r <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          result_r       <= sat_s;
          result_valid_r <= 1'b1;
          state_r        <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.iResultReady) begin
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            state_r        <= ST_IDLE;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          ready_r        <= 1'b0;
          busy_r         <= 1'b0;
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oReady       = ready_r;
  assign bus.oBusy        = busy_r;
  assign bus.oResult      = result_r;
  assign bus.oResultValid = result_valid_r;

endmodule

// File: tb/tb_pe_cube_seq.sv
// Self-checking bench for pe_cube_seq: job-level reference model checked
// every cycle, directed scenarios with literal expectations, random jobs.
module tb_pe_cube_seq;

  localparam int CN  = 3;
  localparam int BN  = 3;
  localparam int AN  = 3;
  localparam int PPC = AN * BN;
  localparam int NPE = CN * PPC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pe_cube_seq_if #(.CUBE_NUM(CN), .BLOCK_NUM(BN), .ARRAY_NUM(AN), .LEN_W(8)) bus ();

  pe_cube_seq #(.CUBE_NUM(CN), .BLOCK_NUM(BN), .ARRAY_NUM(AN), .ACC_W(24), .LEN_W(8)) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [8*NPE-1:0] act, input logic [8*NPE-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level reference model ----------------
  int          phase = 0;   // 0 idle, 1 collecting beats, 2 flush, 3 holding result
  longint      m_acc [NPE];
  int          m_res [NPE];
  bit          m_rv = 1'b0;
  int          m_left = 0;
  logic [PPC-1:0] m_sel = '0;
  int          m_sh = 0;

  function automatic longint wrap24(input longint x);
    longint y;
    y = x & 64'hFFFFFF;
    if (y >= (longint'(1) << 23)) y = y - (longint'(1) << 24);
    return y;
  endfunction

  function automatic int sat8m(input longint a, input int sh);
    longint v;
    v = a >>> sh;
    if (v > 127) return 127;
    if (v < -128) return -128;
    return int'(v);
  endfunction

  initial begin
    logic [8*NPE-1:0] ev;
    int d, w, p;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0; m_rv = 1'b0; m_left = 0; m_sel = '0; m_sh = 0;
        for (int k = 0; k < NPE; k++) begin
          m_acc[k] = 0;
          m_res[k] = 0;
        end
      end
      for (int k = 0; k < NPE; k++) ev[k*8 +: 8] = 8'(m_res[k]);
      chk("busy", bus.oBusy, longint'(phase != 0));
      chk("ready", bus.oReady, longint'(phase == 1));
      chk("result_valid", bus.oResultValid, longint'(m_rv));
      chk_vec("result", bus.oResult, ev);
      if (rst_n) begin
        case (phase)
          0: if (bus.iStart && bus.iLen != 8'd0) begin
               m_left = int'(bus.iLen);
               m_sel  = bus.iSelPattern;
               m_sh   = int'(bus.iShift);
               for (int k = 0; k < NPE; k++) m_acc[k] = 0;
               phase = 1;
             end
          1: if (bus.iValid) begin
               for (int c = 0; c < CN; c++)
                 for (int j = 0; j < BN; j++)
                   for (int i = 0; i < AN; i++) begin
                     p = c * PPC + j * AN + i;
                     d = m_sel[j*AN+i] ? int'($signed(bus.iData2[i*8 +: 8]))
                                       : int'($signed(bus.iData1[i*8 +: 8]));
                     w = int'($signed(bus.iWeight[c*8 +: 8]));
                     m_acc[p] = wrap24(m_acc[p] + longint'(d * w));
                   end
               m_left--;
               if (m_left == 0) phase = 2;
             end
          2: begin
               for (int k = 0; k < NPE; k++) m_res[k] = sat8m(m_acc[k], m_sh);
               m_rv  = 1'b1;
               phase = 3;
             end
          default: if (bus.iResultReady) begin
               m_rv  = 1'b0;
               phase = 0;
             end
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job(input int len, input logic [PPC-1:0] pat, input int sh);
    bus.iStart      = 1'b1;
    bus.iLen        = 8'(len);
    bus.iSelPattern = pat;
    bus.iShift      = 5'(sh);
    cyc();
    bus.iStart      = 1'b0;
    bus.iLen        = 8'($urandom);
    bus.iSelPattern = PPC'($urandom);
    bus.iShift      = 5'($urandom);
  endtask

  task automatic beat(input logic [8*AN-1:0] d1, input logic [8*AN-1:0] d2, input logic [8*CN-1:0] wt);
    bus.iValid  = 1'b1;
    bus.iData1  = d1;
    bus.iData2  = d2;
    bus.iWeight = wt;
    cyc();
    bus.iValid  = 1'b0;
  endtask

  task automatic bubble();
    bus.iValid  = 1'b0;
    bus.iData1  = 24'($urandom);
    bus.iData2  = 24'($urandom);
    bus.iWeight = 24'($urandom);
    cyc();
  endtask

  task automatic get_result(input int hold, input bit poke_start);
    int t;
    t = 0;
    while (!bus.oResultValid && t < 20) begin
      cyc();
      t++;
    end
    chk("result_wait", bus.oResultValid, 1);
    for (int k = 0; k < hold; k++) begin
      bus.iStart = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.iLen   = 8'($urandom_range(1, 255));
      cyc();
    end
    bus.iStart       = poke_start;
    bus.iResultReady = 1'b1;
    cyc();
    bus.iResultReady = 1'b0;
    bus.iStart       = 1'b0;
  endtask

  task automatic lit(input string name, input int idx, input int exp);
    chk(name, longint'(int'($signed(bus.oResult[idx*8 +: 8]))), exp);
    chk({name, "_model"}, m_res[idx], exp);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.iStart = 1'b0; bus.iLen = 8'd0; bus.iSelPattern = '0; bus.iShift = 5'd0;
    bus.iValid = 1'b0; bus.iWeight = '0; bus.iData1 = '0; bus.iData2 = '0;
    bus.iResultReady = 1'b0;
    cyc(3);
    chk("reset_result", longint'(bus.oResult == '0), 1);
    rst_n = 1'b1;
    cyc();

    // single beat: 3*2 everywhere, valid exactly one cycle after the beat
    start_job(1, '0, 0);
    beat(24'h030303, 24'h000000, 24'h020202);
    chk("t1_valid_early", bus.oResultValid, 0);
    cyc();
    chk("t1_valid_rise", bus.oResultValid, 1);
    for (int k = 0; k < NPE; k += 13) lit("t1_byte", k, 6);
    get_result(0, 1'b0);

    // saturation both ways
    start_job(4, '0, 0);
    repeat (4) beat(24'h646464, 24'h000000, 24'h646464);
    get_result(0, 1'b0);
    lit("t2_pos_sat_first", 0, 127);
    lit("t2_pos_sat_last", NPE - 1, 127);
    start_job(4, '0, 0);
    repeat (4) beat(24'h646464, 24'h000000, 24'h9c9c9c);
    get_result(0, 1'b0);
    lit("t2_neg_sat", 13, -128);

    // pattern selects iData2 for block 1 lane 0, shift by 1
    start_job(2, 9'h008, 1);
    repeat (2) beat(24'h000001, 24'h000005, 24'h010000);
    get_result(1, 1'b0);
    lit("t3_pe210", 21, 5);
    lit("t3_pe200", 18, 1);
    lit("t3_pe010", 3, 0);

    // bubbles and a long hold with start pulses ignored
    start_job(3, '0, 0);
    beat(24'h010101, 24'h000000, 24'h010101);
    bubble();
    beat(24'h010101, 24'h000000, 24'h010101);
    bubble();
    beat(24'h010101, 24'h000000, 24'h010101);
    get_result(10, 1'b1);
    lit("t4_bubble_sum", 0, 3);
    lit("t4_bubble_sum_b", 26, 3);
    chk("t4_idle_after_hold", bus.oBusy, 0);

    // reset mid-job aborts, next job starts from scratch
    start_job(5, '0, 0);
    repeat (2) beat(24'h0a0a0a, 24'h000000, 24'h010101);
    rst_n = 1'b0;
    cyc(2);
    chk("t5_reset_clears", longint'(bus.oResult == '0), 1);
    rst_n = 1'b1;
    cyc();
    start_job(1, '0, 0);
    beat(24'h070707, 24'h000000, 24'h010101);
    get_result(0, 1'b0);
    lit("t5_new_job", 4, 7);

    // zero-length start is ignored
    bus.iStart = 1'b1;
    bus.iLen   = 8'd0;
    cyc();
    bus.iStart = 1'b0;
    chk("t6_len0_busy", bus.oBusy, 0);
    cyc(3);
    chk("t6_len0_valid", bus.oResultValid, 0);

    // random jobs
    for (int n = 0; n < 12; n++) begin
      int len;
      int done;
      int guard;
      len = $urandom_range(1, 6);
      start_job(len, PPC'($urandom), $urandom_range(0, 12));
      done = 0;
      guard = 0;
      while (done < len && guard < 60) begin
        if ($urandom_range(0, 2) == 0) begin
          bubble();
        end else begin
          beat(24'($urandom), 24'($urandom), 24'($urandom));
          done++;
        end
        guard++;
      end
      get_result($urandom_range(0, 4), 1'($urandom_range(0, 1)));
      cyc($urandom_range(0, 2));
    end

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
